dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-through, no-write-allocate data cache between the load/store unit and the data-memory bus. It accepts one word-granular access at a time from the LSU, answers load hits from local storage and load misses by a single-word memory read. It forwards every store to memory and merges the store into the line on a hit. It also generates the second word access that the LSU needs for misaligned loads and stores.

## Interface
Parameters:
- LINES, 16: number of one-word lines; power of two, ≥2.
- IDX_W, $clog2(LINES): index width. Tag is addr[31:2+IDX_W].

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- valid  in  1  LSU request present; held until ready
- addr  in  32  byte address from LSU; held while valid
- wdata  in  32  store data, LSB-aligned (unshifted)
- byte_en  in  4  0000 = load; 0001/0011/1111 = store byte/half/word
- ready  out  1  one-cycle pulse: beat complete
- rdata  out  32  full memory word for the completed load beat; valid with ready
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address, [1:0]=00
- mem_wdata  out  32  lane-positioned write data
- mem_be  out  4  lane write enables
- mem_ack  in  1  one-cycle completion; mem_rdata valid with it
- mem_rdata  in  32  read word

## Operation
- Beat tracking: off = addr[1:0]. Beat 0 accesses word addr[31:2]. After a beat-0 ready with off≠0, the 1-bit beat register is set. While valid stays high and addr is unchanged, the next access is beat 1 at word addr[31:2]+1 (32-bit wrap). The beat register clears after a beat-1 ready, when valid is low, or when addr changes.
- Store lanes: beat 0 uses be = (byte_en<<off)[3:0] and data = wdata<<(8·off). Beat 1 uses be = (byte_en<<off)[7:4] and data = wdata>>(32−8·off). If be = 0000 (for example, sb at off=3 in beat 1), the memory write is skipped and the block goes directly to RESP.
- A load always returns the whole word; the LSU performs the extraction.
- FSM states: IDLE, MEM_RD, MEM_WR, RESP.
  - IDLE with valid and a load hit: latch the line data into rdata, then go to RESP.
  - IDLE with valid and a load miss: go to MEM_RD.
  - IDLE with valid and a store: go to MEM_WR.
  - MEM_RD, on mem_ack: write the line (valid, tag, data = mem_rdata), latch rdata, go to RESP.
  - MEM_WR, on mem_ack: if the tag hits, merge the enabled lanes into the line; on a miss, do not allocate. Go to RESP.
  - RESP: drive ready = 1 for one cycle, update the beat register, then go to IDLE.
- A store hit updates the line only at mem_ack, so memory and cache change together.

## Timing
- Reset values: ready=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, state=IDLE, beat=0, all line valid bits=0. Tag and data contents are don't-care.
- Load hit: request seen in cycle N, ready in cycle N+1.
- Miss or store: mem_req is asserted from cycle N+1. If mem_ack arrives in cycle M, ready is asserted in cycle M+1.
- mem_* outputs are registered and remain stable while mem_req=1. mem_req drops in the cycle after mem_ack.
- The minimum spacing between successive ready pulses is 2 cycles. A request is never accepted in RESP.
- If valid drops mid-transaction, the memory transaction still completes and the line is still updated. ready still pulses and is ignored.
- Reset during MEM_RD or MEM_WR aborts the transaction: mem_req drops the next cycle and any late mem_ack is ignored.

## Structure
- type_pkg gains dcache_state_t (IDLE, MEM_RD, MEM_WR, RESP). It reuses the existing addr_t, data_t and byte_en_t.
- One sub-module, dcache_array: valid/tag/data flops, combinational lookup (hit, rdata), a fill port, and a byte-masked update port. The FSM, beat logic and lane shifting stay in dcache.

## Test plan
- Cold load from 0x100; memory returns 0xDEADBEEF after 3 cycles → mem_req with mem_addr=0x100 and mem_we=0, then ready with rdata=0xDEADBEEF. A repeat load gives ready one cycle after valid and no mem_req.
- sb to 0x101 with wdata=0x000000AA after 0x100 is cached → mem_be=0010, mem_wdata=0x0000AA00. The following load returns 0xDEADAAEF.
- Misaligned lw at 0x102 → beat 0 reads 0x100, beat 1 reads 0x104, two ready pulses.
- Misaligned sw at 0x103 with wdata=0x11223344 → beat 0 has be=1000 and data=0x44000000; beat 1 has be=0111 and data=0x00112233.
- Store miss to 0x200 → memory write only; a following load of 0x200 misses and issues mem_req.
- Conflict: load 0x000, then load 0x000+4·LINES → the second access misses and evicts the first; reloading 0x000 misses again. Reset asserted in MEM_RD → mem_req=0 the next cycle and all lines invalid.

Source files
------------

// File: rtl/type_pkg.sv
// Shared scalar types for the load/store path, plus the data-cache FSM state.
package type_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  byte_en_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_RD = 2'd1,
        MEM_WR = 2'd2,
        RESP   = 2'd3
    } dcache_state_t;

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped one-word-per-line storage: valid/tag/data flops, combinational lookup,
// a fill port for load misses and a byte-masked update port for store hits.
module dcache_array
    import type_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] i_word,
    output logic        o_hit,
    output data_t       o_rdata,
    input  logic        i_fill_en,
    input  data_t       i_fill_data,
    input  logic        i_upd_en,
    input  byte_en_t    i_upd_be,
    input  data_t       i_upd_data
);
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag [LINES];
    data_t            r_data [LINES];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;

    assign w_idx   = i_word[IDX_W-1:0];
    assign w_tag   = i_word[29 -: TAG_W];
    assign o_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign o_rdata = r_data[w_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_fill_en) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= i_fill_data;
        end else if (i_upd_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_upd_be[b]) begin
                    r_data[w_idx][8*b +: 8] <= i_upd_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-through, no-write-allocate data cache between LSU and memory bus.
// Splits misaligned accesses into two word beats and positions store lanes.
//
//   state  | meaning
//   IDLE   | waiting for an LSU beat; load hits answered from the array
//   MEM_RD | single-word memory read outstanding (load miss)
//   MEM_WR | memory write outstanding (every store with enabled lanes)
//   RESP   | ready pulse; beat register updated
module dcache
    import type_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     valid,
    input  addr_t    addr,
    input  data_t    wdata,
    input  byte_en_t byte_en,
    output logic     ready,
    output data_t    rdata,
    output logic     mem_req,
    output logic     mem_we,
    output addr_t    mem_addr,
    output data_t    mem_wdata,
    output byte_en_t mem_be,
    input  logic     mem_ack,
    input  data_t    mem_rdata
);
    dcache_state_t r_state;
    logic          r_beat;
    logic          r_cur_beat;
    addr_t         r_beat_addr;
    logic [1:0]    r_off;
    logic          r_ready;
    data_t         r_rdata;
    logic          r_mem_req;
    logic          r_mem_we;
    addr_t         r_mem_addr;
    data_t         r_mem_wdata;
    byte_en_t      r_mem_be;

    logic          w_beat1;
    logic [1:0]    w_off;
    logic [29:0]   w_word;
    logic [7:0]    w_be8;
    logic [63:0]   w_wd64;
    byte_en_t      w_st_be;
    data_t         w_st_data;
    logic          w_is_store;
    logic [29:0]   w_lookup;
    logic          w_hit;
    data_t         w_hit_data;
    logic          w_fill_en;
    logic          w_upd_en;

    assign w_beat1    = r_beat && (addr == r_beat_addr);
    assign w_off      = addr[1:0];
    assign w_word     = addr[31:2] + {29'd0, w_beat1};
    assign w_is_store = (byte_en != 4'b0000);

    // Shift into a double-word window; the low half is beat 0, the high half beat 1.
    assign w_be8      = {4'b0000, byte_en} << w_off;
    assign w_wd64     = {32'd0, wdata} << {w_off, 3'b000};
    assign w_st_be    = w_beat1 ? w_be8[7:4]    : w_be8[3:0];
    assign w_st_data  = w_beat1 ? w_wd64[63:32] : w_wd64[31:0];

    assign w_lookup   = (r_state == IDLE) ? w_word : r_mem_addr[31:2];
    assign w_fill_en  = (r_state == MEM_RD) && mem_ack;
    assign w_upd_en   = (r_state == MEM_WR) && mem_ack && w_hit;

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W)
    ) u_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_word      (w_lookup),
        .o_hit       (w_hit),
        .o_rdata     (w_hit_data),
        .i_fill_en   (w_fill_en),
        .i_fill_data (mem_rdata),
        .i_upd_en    (w_upd_en),
        .i_upd_be    (r_mem_be),
        .i_upd_data  (r_mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_beat      <= 1'b0;
            r_cur_beat  <= 1'b0;
            r_beat_addr <= '0;
            r_off       <= 2'b00;
            r_ready     <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            r_ready <= 1'b0;
            if (!valid || (addr != r_beat_addr)) begin
                r_beat <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (valid) begin
                        r_cur_beat <= w_beat1;
                        r_off      <= w_off;
                        if (!w_is_store) begin
                            if (w_hit) begin
                                r_rdata <= w_hit_data;
                                r_ready <= 1'b1;
                                r_state <= RESP;
                            end else begin
                                r_mem_req  <= 1'b1;
                                r_mem_we   <= 1'b0;
                                r_mem_addr <= {w_word, 2'b00};
                                r_mem_be   <= 4'b0000;
                                r_state    <= MEM_RD;
                            end
                        end else if (w_st_be == 4'b0000) begin
                            r_ready <= 1'b1;
                            r_state <= RESP;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {w_word, 2'b00};
                            r_mem_wdata <= w_st_data;
                            r_mem_be    <= w_st_be;
                            r_state     <= MEM_WR;
                        end
                    end
                end
                MEM_RD: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_rdata   <= mem_rdata;
                        r_ready   <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                MEM_WR: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_ready   <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    r_beat      <= valid && !r_cur_beat && (r_off != 2'b00);
                    r_beat_addr <= addr;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready     = r_ready;
    assign rdata     = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus random accesses checked
// against a word-level memory model and a line-ownership cache model.
module tb_dcache;
    localparam int LINES = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  byte_en = '0;
    logic        ready;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dcache #(.LINES(LINES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .addr      (addr),
        .wdata     (wdata),
        .byte_en   (byte_en),
        .ready     (ready),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] d;
    } req_t;

    req_t        reqq[$];
    req_t        cur;
    logic [31:0] phys_mem [int unsigned];
    logic [31:0] ref_mem  [int unsigned];
    bit          ref_v    [LINES];
    int unsigned ref_word [LINES];
    bit          rsp_en = 1'b1;
    bit          rsp_busy = 1'b0;
    bit          rsp_rand = 1'b0;
    int          rsp_lat = 3;
    int          rsp_wait = 0;

    function automatic logic [31:0] init_word(input int unsigned w);
        return (w * 32'h9E3779B1) + 32'h01234567;
    endfunction

    function automatic logic [31:0] rd_phys(input int unsigned w);
        return phys_mem.exists(w) ? phys_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] rd_ref(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: logs each request, holds it for a latency, then acks once.
    initial begin
        logic [31:0] tmp;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req && rsp_en) begin
                if (!rsp_busy) begin
                    rsp_busy = 1'b1;
                    cur = '{mem_addr, mem_we, mem_be, mem_wdata};
                    reqq.push_back(cur);
                    rsp_wait = rsp_rand ? int'($urandom_range(0, 3)) : rsp_lat;
                end else begin
                    chk("mem_addr_stable", mem_addr, cur.a);
                    chk("mem_wdata_stable", mem_wdata, cur.d);
                    chk("mem_ctl_stable", {27'd0, mem_we, mem_be}, {27'd0, cur.we, cur.be});
                end
                if (rsp_wait == 0) begin
                    mem_ack  = 1'b1;
                    rsp_busy = 1'b0;
                    if (cur.we) begin
                        tmp = rd_phys(cur.a[31:2]);
                        for (int l = 0; l < 4; l++) begin
                            if (cur.be[l]) tmp[8*l +: 8] = cur.d[8*l +: 8];
                        end
                        phys_mem[cur.a[31:2]] = tmp;
                    end else begin
                        mem_rdata = rd_phys(cur.a[31:2]);
                    end
                end else begin
                    rsp_wait--;
                end
            end
        end
    end

    // One LSU access (one or two beats), every beat checked against the models.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input string tag);
        int          nb;
        int          cycles;
        int          size;
        int          off;
        int          idx;
        int unsigned w;
        bit          hit;
        logic [3:0]  ebe;
        logic [31:0] edat;
        logic [31:0] tmp;
        off  = int'(a[1:0]);
        nb   = (off != 0) ? 2 : 1;
        size = (be == 4'b0001) ? 1 : (be == 4'b0011) ? 2 : (be == 4'b1111) ? 4 : 0;
        valid = 1'b1; addr = a; wdata = wd; byte_en = be;
        for (int b = 0; b < nb; b++) begin
            w   = ((a >> 2) + b) & 32'h3FFF_FFFF;
            idx = int'(w % LINES);
            hit = ref_v[idx] && (ref_word[idx] == w);
            ebe  = '0;
            edat = '0;
            for (int l = 0; l < 4; l++) begin
                int k;
                k = 4 * b + l - off;
                if (k >= 0 && k < 4) edat[8*l +: 8] = wd[8*k +: 8];
                if (k >= 0 && k < size) ebe[l] = 1'b1;
            end
            reqq.delete();
            cycles = 0;
            do begin
                @(negedge clk);
                cycles++;
            end while (!ready && cycles < 200);
            chk({tag, "_ready"}, 32'(ready), 32'd1);
            if (size != 0 && ebe == 4'b0000) begin
                chk({tag, "_skip_nreq"}, reqq.size(), 0);
                chk({tag, "_skip_lat"}, cycles, (b == 0) ? 1 : 2);
            end else if (size != 0) begin
                chk({tag, "_st_nreq"}, reqq.size(), 1);
                if (reqq.size() == 1) begin
                    chk({tag, "_st_addr"}, reqq[0].a, {w[29:0], 2'b00});
                    chk({tag, "_st_we"}, 32'(reqq[0].we), 32'd1);
                    chk({tag, "_st_be"}, 32'(reqq[0].be), 32'(ebe));
                    chk({tag, "_st_data"}, reqq[0].d, edat);
                end
                tmp = rd_ref(w);
                for (int l = 0; l < 4; l++) begin
                    if (ebe[l]) tmp[8*l +: 8] = edat[8*l +: 8];
                end
                ref_mem[w] = tmp;
            end else if (hit) begin
                chk({tag, "_hit_nreq"}, reqq.size(), 0);
                chk({tag, "_hit_lat"}, cycles, (b == 0) ? 1 : 2);
                chk({tag, "_hit_rdata"}, rdata, rd_ref(w));
            end else begin
                chk({tag, "_miss_nreq"}, reqq.size(), 1);
                if (reqq.size() == 1) begin
                    chk({tag, "_miss_addr"}, reqq[0].a, {w[29:0], 2'b00});
                    chk({tag, "_miss_we"}, 32'(reqq[0].we), 32'd0);
                end
                chk({tag, "_miss_rdata"}, rdata, rd_ref(w));
                ref_v[idx]    = 1'b1;
                ref_word[idx] = w;
            end
        end
        valid = 1'b0; byte_en = '0;
        @(negedge clk);
        chk({tag, "_ready_pulse"}, 32'(ready), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [3:0]  rbe;
        phys_mem[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40]  = 32'hDEADBEEF;
        for (int i = 0; i < LINES; i++) ref_v[i] = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        access(32'h100, 32'h0, 4'b0000, "cold_ld");
        chk("cold_ld_value", rdata, 32'hDEADBEEF);
        access(32'h100, 32'h0, 4'b0000, "rep_ld");
        access(32'h101, 32'h0000_00AA, 4'b0001, "sb_101");
        access(32'h100, 32'h0, 4'b0000, "ld_after_sb");
        chk("sb_merge_value", rdata, 32'hDEADAAEF);
        access(32'h102, 32'h0, 4'b0000, "lw_mis");
        access(32'h103, 32'h1122_3344, 4'b1111, "sw_mis");
        access(32'h103, 32'h0000_0055, 4'b0001, "sb_off3");
        access(32'h200, 32'hCAFE_F00D, 4'b1111, "st_miss");
        access(32'h200, 32'h0, 4'b0000, "ld_after_stmiss");
        access(32'h000, 32'h0, 4'b0000, "conf_a");
        access(32'h000 + 4 * LINES, 32'h0, 4'b0000, "conf_b");
        access(32'h000, 32'h0, 4'b0000, "conf_a2");
        access(32'hFFFF_FFFE, 32'h0, 4'b0000, "wrap_lw");
        access(32'hFFFF_FFFF, 32'hA1B2_C3D4, 4'b0011, "wrap_sh");

        rsp_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            ra = {22'd0, 8'($urandom_range(0, 47)), 2'($urandom_range(0, 3))};
            case ($urandom_range(0, 4))
                0, 1:    rbe = 4'b0000;
                2:       rbe = 4'b0001;
                3:       rbe = 4'b0011;
                default: rbe = 4'b1111;
            endcase
            access(ra, $urandom, rbe, "rnd");
        end
        rsp_rand = 1'b0;

        rsp_en = 1'b0;
        valid = 1'b1; addr = 32'h7000_0000; byte_en = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_mid_req_before", 32'(mem_req), 32'd1);
        valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_req_drop", 32'(mem_req), 32'd0);
        chk("rst_mid_ready", 32'(ready), 32'd0);
        rst_n = 1'b1;
        rsp_busy = 1'b0;
        rsp_en = 1'b1;
        for (int i = 0; i < LINES; i++) ref_v[i] = 1'b0;
        @(negedge clk);
        access(32'h100, 32'h0, 4'b0000, "post_rst_ld");
        access(32'h000, 32'h0, 4'b0000, "post_rst_ld0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
